// File: rtl/uu_acmac_tx_mem_reader.sv
// TX frame memory reader: fetches len_words 32-bit words starting at base_addr
// from a one-cycle-latency memory and streams them out through a 2-entry FIFO.
module uu_acmac_tx_mem_reader #(
  parameter int MEM_DEPTH = 208,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        len_words,
  input  logic              abort,
  output logic              mem_tx_in_en,
  output logic              mem_tx_in_wen,
  output logic [ADDR_W-1:0] mem_tx_in_addr,
  output logic [31:0]       mem_tx_in_data,
  input  logic [31:0]       mem_tx_out_data,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_W = AW1'(MEM_DEPTH);

  logic [1:0]      state_q;
  logic [ADDR_W:0] rd_addr_q;
  logic [7:0]      rd_left_q;
  logic            rd_pend_q;
  logic            rd_pend_last_q;
  logic            err_q;

  logic [31:0]     fifo_data [2];
  logic [1:0]      fifo_last;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      fifo_cnt_q;

  logic            pop;
  logic            push;
  logic            abort_now;
  logic            can_issue;
  logic            issue_last;
  logic            frame_bad;
  logic [ADDR_W:0] frame_end;
  logic [2:0]      occupancy;
  logic [2:0]      limit;

  // Frame end is computed one bit wider than the address so it cannot wrap.
  assign frame_end = {1'b0, base_addr} + {{(ADDR_W-7){1'b0}}, len_words};
  assign frame_bad = (len_words == 8'd0) || (frame_end > DEPTH_W);

  assign pop       = out_valid & out_ready;
  assign abort_now = abort && (state_q != S_IDLE);
  assign push      = rd_pend_q && !abort_now;

  // A read issued now lands in the FIFO two edges from now; it may only go
  // out if the FIFO can hold it even when nothing is popped next cycle.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};
  assign limit     = 3'd2 + {2'b00, pop};
  assign can_issue = occupancy < limit;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_tx_in_en   = 1'b0;
    mem_tx_in_addr = '0;
    issue_last     = 1'b0;
    if (state_q == S_FETCH && !abort && can_issue && !rd_addr_q[ADDR_W]) begin
      mem_tx_in_en   = 1'b1;
      mem_tx_in_addr = rd_addr_q[ADDR_W-1:0];
      issue_last     = (rd_left_q == 8'd1);
    end
  end

  assign mem_tx_in_wen  = 1'b0;
  assign mem_tx_in_data = 32'd0;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr_q] : 32'd0;
  assign out_last  = out_valid ? fifo_last[rd_ptr_q] : 1'b0;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_addr_q      <= '0;
      rd_left_q      <= 8'd0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      err_q          <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      err_q          <= (state_q == S_IDLE) && start && frame_bad;
      rd_pend_q      <= mem_tx_in_en;
      rd_pend_last_q <= issue_last;

      case (state_q)
        S_IDLE: begin
          if (start && !frame_bad) begin
            state_q   <= S_FETCH;
            rd_addr_q <= {1'b0, base_addr};
            rd_left_q <= len_words;
          end
        end
        S_FETCH: begin
          if (mem_tx_in_en) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            rd_left_q <= rd_left_q - 8'd1;
            if (issue_last) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (abort_now) begin
        state_q    <= S_IDLE;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; the count qualifies it and out_data is
  // gated by out_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= mem_tx_out_data;
      fifo_last[wr_ptr_q] <= rd_pend_last_q;
    end
  end

endmodule

// File: tb/tb_uu_acmac_tx_mem_reader.sv
// Scoreboard bench for uu_acmac_tx_mem_reader: expected words are queued at
// start from a memory image; a negedge monitor pops and compares accepted words.
module tb_uu_acmac_tx_mem_reader;

  localparam int MEM_DEPTH = 208;
  localparam int ADDR_W    = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        len_words = 8'd0;
  logic              abort = 1'b0;
  logic              mem_tx_in_en;
  logic              mem_tx_in_wen;
  logic [ADDR_W-1:0] mem_tx_in_addr;
  logic [31:0]       mem_tx_in_data;
  logic [31:0]       mem_tx_out_data = 32'd0;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_last;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
  logic              err;

  uu_acmac_tx_mem_reader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .len_words      (len_words),
    .abort          (abort),
    .mem_tx_in_en   (mem_tx_in_en),
    .mem_tx_in_wen  (mem_tx_in_wen),
    .mem_tx_in_addr (mem_tx_in_addr),
    .mem_tx_in_data (mem_tx_in_data),
    .mem_tx_out_data(mem_tx_out_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic [31:0] mem [MEM_DEPTH];
  exp_t        exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;

  // Per-frame bookkeeping shared between stimulus and monitor.
  int issued, accepted, last_rd_addr;
  int first_en_cyc, first_valid_cyc, last_acc_cyc, start_edge;
  int f_base, f_len;
  bit f_ok, frame_done, done_due, stall_prev;
  logic [31:0] stall_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    stall_prev = 1'b0;
    done_due   = 1'b0;
    issued     = 0;
    accepted   = 0;
  endtask

  // One-cycle-latency read memory.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_tx_in_en && int'(mem_tx_in_addr) < MEM_DEPTH)
      mem_tx_out_data <= mem[mem_tx_in_addr];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: cycle numbers below are "cyc at negedge", i.e. the cycle that
  // ends at edge cyc+1.
  always @(negedge clk) begin
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (stall_prev) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, stall_data);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_data, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
      accepted++;
      last_acc_cyc = cyc;
    end
    if (done || done_due) begin
      check("done", done, done_due);
      if (done) frame_done = 1'b1;
    end
    done_due   = out_valid && out_ready && out_last;
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (mem_tx_in_en) begin
      if (first_en_cyc < 0) first_en_cyc = cyc;
      issued++;
      check("credit", (issued - accepted) <= 2, 1'b1);
      check("mem_wr", {mem_tx_in_wen, mem_tx_in_data}, 0);
      last_rd_addr = int'(mem_tx_in_addr);
    end
  end

  // Call just after a rising edge.
  task automatic start_frame(input int b, input int l, input bit chk_zero);
    f_base = b;
    f_len  = l;
    f_ok   = (l != 0) && (b + l <= MEM_DEPTH);
    flush();
    frame_done      = 1'b0;
    first_en_cyc    = -1;
    first_valid_cyc = -1;
    if (f_ok) begin
      for (int i = 0; i < l; i++) begin
        exp_t e;
        e.data = mem[b + i];
        e.last = (i == l - 1);
        exp_q.push_back(e);
      end
    end
    base_addr  = ADDR_W'(b);
    len_words  = 8'(l);
    start      = 1'b1;
    start_edge = cyc + 1;
    if (chk_zero) begin
      @(negedge clk);
      check("rst_outputs",
            {mem_tx_in_en, mem_tx_in_addr, out_valid, out_data, out_last, busy, done, err}, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err, !f_ok);
    check("busy_after_start", busy, f_ok);
  endtask

  task automatic finish_frame(input int abort_after);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (abort_after >= 0 && accepted >= abort_after) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        flush();
        @(negedge clk);
        check("abort_state", {out_valid, busy, done}, 0);
        return;
      end
      if (frame_done) begin
        check("frame_queue_empty", exp_q.size(), 0);
        check("frame_reads", issued, f_len);
        check("final_addr", last_rd_addr, f_base + f_len - 1);
        return;
      end
    end
    check("frame_timeout", 0, 1);
  endtask

  task automatic bad_frame(input int b, input int l);
    @(posedge clk);
    #1;
    start_frame(b, l, 1'b0);
    repeat (4) @(negedge clk);
    check("bad_frame_idle", {busy, issued != 0}, 0);
  endtask

  initial begin
    flush();
    frame_done = 1'b0;
    first_en_cyc = -1;
    first_valid_cyc = -1;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          {mem_tx_in_en, out_valid, out_last, busy, done, err, mem_tx_in_wen}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Base 0, 4 words, ready held high: latency and no bubbles.
    ready_mode = 0;
    start_frame(0, 4, 1'b0);
    finish_frame(-1);
    check("first_read_cycle", first_en_cyc + 1 - start_edge, 1);
    check("first_valid_cycle", first_valid_cyc + 1 - start_edge, 3);
    check("no_bubbles", last_acc_cyc - first_valid_cyc, 3);

    // Base 10, 6 words, ready toggling.
    ready_mode = 1;
    @(posedge clk);
    #1;
    start_frame(10, 6, 1'b0);
    finish_frame(-1);

    // Rejected frames.
    ready_mode = 0;
    bad_frame(5, 0);
    bad_frame(205, 4);

    // Frame ending at the last memory word.
    @(posedge clk);
    #1;
    start_frame(200, 8, 1'b0);
    finish_frame(-1);

    // Abort after three words, then a short frame.
    @(posedge clk);
    #1;
    start_frame(20, 10, 1'b0);
    finish_frame(3);
    @(posedge clk);
    #1;
    start_frame(30, 2, 1'b0);
    finish_frame(-1);

    // Reset mid-fetch, then start on the first cycle after reset.
    @(posedge clk);
    #1;
    start_frame(50, 20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_frame(60, 3, 1'b1);
    finish_frame(-1);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      int b, l, ab;
      ready_mode = $urandom_range(0, 2);
      b  = $urandom_range(0, 230);
      l  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      ab = -1;
      if (l > 1 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, l - 1);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      start_frame(b, l, 1'b0);
      if (f_ok) finish_frame(ab);
      else begin
        repeat (3) @(negedge clk);
        check("rand_bad_idle", {busy, issued != 0}, 0);
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
